// File: rtl/counter_sequencer_pkg.sv
// Shared definitions for the LED counter sequencer: FSM encodings,
// button slot indices and a constant-width helper.
package counter_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  // Slot of each raw button in the packed synchronizer vectors
  localparam int B_RUN   = 0;
  localparam int B_DIR   = 1;
  localparam int B_CLR   = 2;
  localparam int B_LOAD  = 3;
  localparam int NUM_BTN = 4;

  // Bits needed to hold values 0..v-1
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/counter_sequencer_tick_prescaler.sv
// Divide-by-DIV prescaler: counts while enabled, emits a one-cycle tick
// when it reaches DIV-1 and folds back to zero on the following edge.
module tick_prescaler
  import counter_defs::*;
#(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = clog2(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  if (DIV < 2) begin : g_div_chk
    $error("tick_prescaler: DIV must be >= 2");
  end

  logic [PW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // Count while enabled; hold when disabled so a pause resumes mid-period
  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (en)
      cnt <= tick ? '0 : cnt + PW'(1);
  end

endmodule

// File: rtl/counter_sequencer.sv
// Run/pause/direction/clear/load sequencer for the board LED counter.
// Raw buttons are synchronized and edge-detected here; the count register
// steps on the internally generated slow tick.
module counter_sequencer
  import counter_defs::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1,
  parameter int WIDTH   = 4,
  parameter int WRAP    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_run,
  input  logic             btn_dir,
  input  logic             btn_clr,
  input  logic             btn_load,
  input  logic [WIDTH-1:0] sw_val,
  output logic [WIDTH-1:0] leds,
  output logic             running,
  output logic             dir_up,
  output logic             tick,
  output logic             limit
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam bit WRAP_EN = (WRAP != 0);
  localparam logic [WIDTH-1:0] MAXV = '1;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  // ---------------- button synchronizers / edge detect ----------------
  logic [NUM_BTN-1:0] btn_raw, sync1, sync2, dly, pulse;

  assign btn_raw = {btn_load, btn_clr, btn_dir, btn_run};
  assign pulse   = sync2 & ~dly;

  // Two-flop synchronizer plus one delay stage per button
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      dly   <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      dly   <= sync2;
    end
  end

  logic run_p, dir_p, clr_p, load_p;
  assign run_p  = pulse[B_RUN];
  assign dir_p  = pulse[B_DIR];
  assign clr_p  = pulse[B_CLR];
  assign load_p = pulse[B_LOAD];

  // ---------------- prescaler ----------------
  state_t state, state_nx;
  logic   tick_i;

  tick_prescaler #(.DIV(DIV)) u_presc (
    .clk  (clk),
    .rst  (rst),
    .en   (state == ST_RUN),
    .clr  ((state == ST_IDLE) && run_p),
    .tick (tick_i)
  );

  // ---------------- FSM + count register ----------------
  logic [WIDTH-1:0] leds_q, leds_nx;
  logic             dir_q, dir_nx;
  logic             at_lim, limit_c, sat;

  assign at_lim = dir_q ? (leds_q == MAXV) : (leds_q == '0);

  // Next state / count: clr > load > tick step > run toggle
  always_comb begin
    state_nx = state;
    leds_nx  = leds_q;
    dir_nx   = dir_q ^ dir_p;
    limit_c  = 1'b0;
    sat      = 1'b0;
    if (clr_p) begin
      leds_nx = '0;
    end else if (load_p) begin
      leds_nx = sw_val;
    end else if (tick_i) begin
      limit_c = at_lim;
      // Modulo arithmetic gives the wrap for free; saturation just holds
      if (WRAP_EN || !at_lim)
        leds_nx = dir_q ? leds_q + ONE : leds_q - ONE;
      else
        sat = 1'b1;
    end
    if (sat) begin
      state_nx = ST_IDLE;
    end else if (run_p) begin
      case (state)
        ST_IDLE:  state_nx = ST_RUN;
        ST_RUN:   state_nx = ST_PAUSE;
        ST_PAUSE: state_nx = ST_RUN;
        default:  state_nx = ST_IDLE;
      endcase
    end
  end

  // State, direction and count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      leds_q <= '0;
      dir_q  <= 1'b1;
    end else begin
      state  <= state_nx;
      leds_q <= leds_nx;
      dir_q  <= dir_nx;
    end
  end

  assign leds    = leds_q;
  assign running = (state == ST_RUN);
  assign dir_up  = dir_q;
  assign tick    = tick_i;
  assign limit   = limit_c;

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer with DIV=10, WIDTH=4. dut_a wraps, dut_b
// saturates. Expected step results for dut_a go into a queue; a monitor
// pops one entry per tick and checks limit then the stepped count.
module tb_counter_sequencer;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic       btn_run, btn_dir, btn_clr, btn_load;
  logic [3:0] sw_val;
  logic [3:0] leds_a, leds_b;
  logic       running_a, running_b, dir_up_a, dir_up_b;
  logic       tick_a, tick_b, limit_a, limit_b;

  always #5 clk = ~clk;

  counter_sequencer #(.CLK_HZ(10), .TICK_HZ(1), .WIDTH(4), .WRAP(1)) dut_a (
    .clk(clk), .rst(rst_a), .btn_run(btn_run), .btn_dir(btn_dir),
    .btn_clr(btn_clr), .btn_load(btn_load), .sw_val(sw_val), .leds(leds_a),
    .running(running_a), .dir_up(dir_up_a), .tick(tick_a), .limit(limit_a));

  counter_sequencer #(.CLK_HZ(10), .TICK_HZ(1), .WIDTH(4), .WRAP(0)) dut_b (
    .clk(clk), .rst(rst_b), .btn_run(btn_run), .btn_dir(btn_dir),
    .btn_clr(btn_clr), .btn_load(btn_load), .sw_val(sw_val), .leds(leds_b),
    .running(running_b), .dir_up(dir_up_b), .tick(tick_b), .limit(limit_b));

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0] leds;
    logic       lim;
  } exp_t;

  exp_t       q[$];
  exp_t       mon_e;
  logic       pend = 1'b0;
  logic [3:0] pend_leds;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitor for dut_a
  always @(negedge clk) begin
    if (rst_a) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        check("step_leds", leds_a, pend_leds);
        pend = 1'b0;
      end
      if (tick_a) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_tick leds=%0d t=%0t", leds_a, $time);
        end else begin
          mon_e = q.pop_front();
          check("tick_limit", limit_a, mon_e.lim);
          pend_leds = mon_e.leds;
          pend      = 1'b1;
        end
      end else if (limit_a) begin
        check("stray_limit", limit_a, 0);
      end
    end
  end

  // Drive the masked buttons {load,clr,dir,run} for `hold` rising edges
  task automatic press(input logic [3:0] m, input int hold);
    {btn_load, btn_clr, btn_dir, btn_run} = m;
    repeat (hold) @(posedge clk);
    #1 {btn_load, btn_clr, btn_dir, btn_run} = 4'b0;
  endtask

  // Rising edges until the selected tick is seen (sampled on falling edge)
  task automatic wait_tick(input bit sel_b, output int n);
    logic tk;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
      tk = sel_b ? tick_b : tick_a;
    end while (!tk && n < 200);
    if (!tk) begin
      total++;
      bad++;
      $display("FAIL tick_timeout waited=%0d", n);
    end
  endtask

  function automatic exp_t mk(input int v, input bit lim);
    exp_t e;
    e.leds = v[3:0];
    e.lim  = lim;
    return e;
  endfunction

  initial begin
    int n, nt;
    rst_a = 1'b1; rst_b = 1'b1;
    {btn_load, btn_clr, btn_dir, btn_run} = 4'b0;
    sw_val = 4'd0;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_leds", leds_a, 0);
    check("rst_running", running_a, 0);
    check("rst_dir_up", dir_up_a, 1);
    check("rst_tick", tick_a, 0);
    check("rst_limit", limit_a, 0);
    @(posedge clk); #1 rst_a = 1'b0;

    // ---- 1: start, first tick and spacing ----
    q.push_back(mk(1, 0));
    q.push_back(mk(2, 0));
    press(4'b0001, 3);
    @(negedge clk);
    check("run_after_press", running_a, 1);
    wait_tick(0, n);
    check("first_tick_delay", n, 9);   // tick visible on 9th edge, step on 10th
    wait_tick(0, n);
    check("tick_spacing", n, 10);

    // ---- 2: up-wrap, then down-wrap ----
    for (int v = 3; v <= 16; v++) begin
      q.push_back(mk(v % 16, v == 16));
      wait_tick(0, n);
    end
    check("spacing_at_wrap", n, 10);
    press(4'b0010, 3);
    @(negedge clk);
    check("dir_down", dir_up_a, 0);
    q.push_back(mk(15, 1));
    wait_tick(0, n);
    press(4'b0010, 3);
    @(negedge clk);
    check("dir_up_again", dir_up_a, 1);
    q.push_back(mk(0, 1));
    wait_tick(0, n);

    // ---- 3: pause with prescaler held at 4, resume ----
    @(posedge clk);
    @(posedge clk);
    #1 press(4'b0001, 3);
    @(negedge clk);
    check("paused", running_a, 0);
    repeat (50) @(posedge clk);
    @(negedge clk);
    check("frozen_leds", leds_a, 0);
    q.push_back(mk(1, 0));
    press(4'b0001, 3);
    wait_tick(0, n);
    check("resume_delay", n, 5);       // step lands 6 edges after resume

    // ---- 4: load on a tick cycle, clr+load together ----
    sw_val = 4'd9;
    q.push_back(mk(9, 0));
    q.push_back(mk(10, 0));
    repeat (8) @(posedge clk);
    #1 press(4'b1000, 3);
    wait_tick(0, n);
    sw_val = 4'd5;
    press(4'b1100, 3);
    @(negedge clk);
    check("clr_beats_load", leds_a, 0);
    q.push_back(mk(1, 0));
    wait_tick(0, n);

    // ---- 6: reset mid-run, held button ----
    sw_val = 4'd7;
    press(4'b1000, 3);
    @(negedge clk);
    check("loaded_7", leds_a, 7);
    @(posedge clk); #1 rst_a = 1'b1;
    @(posedge clk); #1 rst_a = 1'b0;
    @(negedge clk);
    check("midrun_rst_leds", leds_a, 0);
    check("midrun_rst_running", running_a, 0);
    check("midrun_rst_dir", dir_up_a, 1);
    check("midrun_rst_tick", tick_a, 0);
    nt = 0;
    repeat (20) begin
      @(negedge clk);
      if (tick_a) nt++;
    end
    check("no_tick_after_rst", nt, 0);
    @(posedge clk); #1 btn_dir = 1'b1;
    repeat (30) @(posedge clk);
    #1 btn_dir = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("held_dir_one_toggle", dir_up_a, 0);

    // ---- 5: saturating instance ----
    @(posedge clk); #1 rst_a = 1'b1; rst_b = 1'b0;
    sw_val = 4'd14;
    press(4'b1000, 3);
    @(negedge clk);
    check("b_loaded_14", leds_b, 14);
    press(4'b0001, 3);
    @(negedge clk);
    check("b_running", running_b, 1);
    wait_tick(1, n);
    check("b_limit_14", limit_b, 0);
    @(negedge clk);
    check("b_leds_15", leds_b, 15);
    wait_tick(1, n);
    check("b_limit_sat", limit_b, 1);
    @(negedge clk);
    check("b_leds_held", leds_b, 15);
    check("b_idle", running_b, 0);
    nt = 0;
    repeat (30) begin
      @(negedge clk);
      if (tick_b) nt++;
    end
    check("b_no_tick_idle", nt, 0);

    check("sb_drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
